mmio_mem: RTL



---
 rtl/mmio_mem.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mmio_mem.sv
// Unified instruction/data RAM with an I/O window: RAND (LFSR), PFLAG (player edge flags), SNAP (player score snapshot).
// Optional `MMIO_FAULT_EN adds a sticky fault flag and address at IO_BASE+3; INIT_FILE names the RAM image for the load flow.
module mmio_mem #(
  parameter int                   WIDTH       = 16,
  parameter int                   ADDR_BITS   = 16,
  parameter int                   DEPTH       = 256,
  parameter int                   NUM_PLAYERS = 4,
  parameter int                   PLAYER_BASE = 32,
  parameter logic [ADDR_BITS-1:0] IO_BASE     = 16'hFFF0,
  parameter logic [15:0]          LFSR_SEED   = 16'hACE1,
  parameter string                INIT_FILE   = "mem_init.dat"
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         memwrite,
  input  logic                         memread,
  input  logic [ADDR_BITS-1:0]         adr,
  input  logic [WIDTH-1:0]             writedata,
  output logic [WIDTH-1:0]             memdata,
  input  logic [ADDR_BITS-1:0]         ifetch_adr,
  output logic [WIDTH-1:0]             instruction,
  input  logic [NUM_PLAYERS-1:0]       player_in,
  output logic [WIDTH-1:0]             snap_val,
  output logic [NUM_PLAYERS*WIDTH-1:0] snap_players,
  output logic                         snap_valid
`ifdef MMIO_FAULT_EN
  ,
  output logic                         fault
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_BITS-1:0] DEPTH_A = ADDR_BITS'(DEPTH);
  localparam logic [ADDR_BITS-1:0] A_RAND  = IO_BASE;
  localparam logic [ADDR_BITS-1:0] A_PFLAG = IO_BASE + ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] A_SNAP  = IO_BASE + ADDR_BITS'(2);
  localparam logic [15:0]          LFSR_MASK = 16'hB400;

  logic [WIDTH-1:0]             mem_q [DEPTH];
  logic [WIDTH-1:0]             memdata_q, memdata_d;
  logic [WIDTH-1:0]             instr_q, instr_d;
  logic [WIDTH-1:0]             snap_val_q, snap_val_d;
  logic [NUM_PLAYERS*WIDTH-1:0] snap_pl_q, snap_pl_d;
  logic                         snap_valid_q, snap_valid_d;
  logic [15:0]                  lfsr_q, lfsr_d;
  logic [NUM_PLAYERS-1:0]       sync1_q, sync2_q, sync3_q;
  logic [NUM_PLAYERS-1:0]       flags_q, flags_d, rise;
  logic [WIDTH-1:0]             rd_data;
  logic                         rd_en, wr_en, ram_hit, fetch_hit;
  logic                         rand_hit, pflag_hit, snap_hit;

`ifdef MMIO_FAULT_EN
  localparam logic [ADDR_BITS-1:0] A_FAULT = IO_BASE + ADDR_BITS'(3);
  logic                 fault_q, fault_d;
  logic [ADDR_BITS-1:0] fault_adr_q, fault_adr_d;
  logic                 fault_hit, data_bad;
`endif

  always_comb begin
    rd_en     = en & memread;
    wr_en     = en & memwrite;
    ram_hit   = adr < DEPTH_A;
    fetch_hit = ifetch_adr < DEPTH_A;
    rand_hit  = adr == A_RAND;
    pflag_hit = adr == A_PFLAG;
    snap_hit  = adr == A_SNAP;

    rd_data = '0;
    if (ram_hit)        rd_data = mem_q[adr[AW-1:0]];
    else if (rand_hit)  rd_data = WIDTH'(lfsr_q);
    else if (pflag_hit) rd_data = WIDTH'(flags_q);
`ifdef MMIO_FAULT_EN
    else if (fault_hit) rd_data = WIDTH'(fault_adr_q);
`endif
    memdata_d = rd_en ? rd_data : memdata_q;

    // Non-blocking RAM update makes both read ports see the pre-write word.
    instr_d = fetch_hit ? mem_q[ifetch_adr[AW-1:0]] : '0;

    // A new edge in the same cycle as the clearing read survives.
    rise    = sync2_q & ~sync3_q;
    flags_d = (rd_en && pflag_hit) ? rise : (flags_q | rise);

    snap_valid_d = wr_en && snap_hit;
    snap_val_d   = snap_valid_d ? writedata : snap_val_q;
    snap_pl_d    = snap_pl_q;
    if (snap_valid_d) begin
      for (int i = 0; i < NUM_PLAYERS; i++)
        snap_pl_d[i*WIDTH +: WIDTH] = mem_q[AW'(PLAYER_BASE + i)];
    end

    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
  end

`ifdef MMIO_FAULT_EN
  always_comb begin
    fault_hit = adr == A_FAULT;
    data_bad  = ((rd_en || wr_en) && !(ram_hit || rand_hit || pflag_hit || snap_hit || fault_hit))
             || (wr_en && (rand_hit || pflag_hit));
    fault_d     = fault_q;
    fault_adr_d = fault_adr_q;
    if (wr_en && fault_hit) begin
      fault_d     = 1'b0;
      fault_adr_d = '0;
    end else if (!fault_q && (data_bad || !fetch_hit)) begin
      fault_d     = 1'b1;
      fault_adr_d = data_bad ? adr : ifetch_adr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q     <= 1'b0;
      fault_adr_q <= '0;
    end else begin
      fault_q     <= fault_d;
      fault_adr_q <= fault_adr_d;
    end
  end

  assign fault = fault_q;
`endif

  always_ff @(posedge clk) begin
    if (wr_en && ram_hit) mem_q[adr[AW-1:0]] <= writedata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memdata_q    <= '0;
      instr_q      <= '0;
      snap_val_q   <= '0;
      snap_pl_q    <= '0;
      snap_valid_q <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      sync1_q      <= '0;
      sync2_q      <= '0;
      sync3_q      <= '0;
      flags_q      <= '0;
    end else begin
      memdata_q    <= memdata_d;
      instr_q      <= instr_d;
      snap_val_q   <= snap_val_d;
      snap_pl_q    <= snap_pl_d;
      snap_valid_q <= snap_valid_d;
      lfsr_q       <= lfsr_d;
      sync1_q      <= player_in;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      flags_q      <= flags_d;
    end
  end

  assign memdata      = memdata_q;
  assign instruction  = instr_q;
  assign snap_val     = snap_val_q;
  assign snap_players = snap_pl_q;
  assign snap_valid   = snap_valid_q;

endmodule
